// File: rtl/video_packet_scheduler.sv
// video_packet_scheduler: walks one video frame line by line and issues the
// ordered packet requests (VSS/HSS, HBP, RGB, HFP or blanking) to a packet
// assembler, holding each request until it is acknowledged.
// Optional feature macro: BLANK_LPM_EN -- blanking lines request LPM
// (length 0) instead of one long HFP spanning the whole line.
module video_packet_scheduler #(
  parameter int V_W = 12,
  parameter int L_W = 16
) (
  input  logic           clk_sys,
  input  logic           rst_n,
  input  logic           enable,
  input  logic [V_W-1:0] cfg_vsa,
  input  logic [V_W-1:0] cfg_vbp,
  input  logic [V_W-1:0] cfg_vact,
  input  logic [V_W-1:0] cfg_vfp,
  input  logic [L_W-1:0] cfg_hbp,
  input  logic [L_W-1:0] cfg_hact,
  input  logic [L_W-1:0] cfg_hfp,
  output logic           pkt_req,
  output logic [2:0]     pkt_type,
  output logic [L_W-1:0] pkt_len,
  input  logic           pkt_ack,
  output logic           frame_start,
  output logic [V_W-1:0] line_cnt,
  output logic           busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_HBP, S_RGB, S_HFP, S_BLANK, S_LINE_END
  } state_t;

  localparam logic [2:0] PKT_VSS = 3'd0;
  localparam logic [2:0] PKT_HSS = 3'd1;
  localparam logic [2:0] PKT_HBP = 3'd2;
  localparam logic [2:0] PKT_RGB = 3'd3;
  localparam logic [2:0] PKT_HFP = 3'd4;
`ifdef BLANK_LPM_EN
  localparam logic [2:0] PKT_LPM = 3'd5;
`endif

  localparam logic [V_W+1:0] ONE_LINE = (V_W+2)'(1);

  state_t         r_state;
  state_t         w_next;
  logic [V_W+1:0] r_line;       // two spare bits so a full-size frame cannot alias
  logic [V_W+1:0] w_line_nxt;
  logic           w_capture;
  logic           r_entered;    // first cycle after any state change

  logic [V_W-1:0] r_vsa, r_vbp, r_vact, r_vfp;
  logic [L_W-1:0] r_hbp, r_hact, r_hfp;

  // Live total decides whether a frame may start; shadow sums steer the frame.
  logic [V_W+1:0] w_cfg_total;
  logic [V_W+1:0] w_total;
  logic [V_W+1:0] w_act_lo;
  logic [V_W+1:0] w_act_hi;
  logic           w_active;
  logic           w_last;

  assign w_cfg_total = {2'b00, cfg_vsa} + {2'b00, cfg_vbp} + {2'b00, cfg_vact} + {2'b00, cfg_vfp};
  assign w_total     = {2'b00, r_vsa} + {2'b00, r_vbp} + {2'b00, r_vact} + {2'b00, r_vfp};
  assign w_act_lo    = {2'b00, r_vsa} + {2'b00, r_vbp};
  assign w_act_hi    = w_act_lo + {2'b00, r_vact};
  assign w_active    = (r_line >= w_act_lo) && (r_line < w_act_hi);
  assign w_last      = (r_line == w_total - ONE_LINE);

`ifndef BLANK_LPM_EN
  // A blanking line spans the whole horizontal period; clamp if it overflows.
  logic [L_W+1:0] w_hsum;
  logic [L_W-1:0] w_blank_len;
  assign w_hsum      = {2'b00, r_hbp} + {2'b00, r_hact} + {2'b00, r_hfp};
  assign w_blank_len = (|w_hsum[L_W+1:L_W]) ? {L_W{1'b1}} : w_hsum[L_W-1:0];
`endif

  // State, line counter and shadow configuration registers.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_line    <= '0;
      r_entered <= 1'b0;
      r_vsa     <= '0;
      r_vbp     <= '0;
      r_vact    <= '0;
      r_vfp     <= '0;
      r_hbp     <= '0;
      r_hact    <= '0;
      r_hfp     <= '0;
    end else begin
      r_state   <= w_next;
      r_line    <= w_line_nxt;
      r_entered <= (w_next != r_state);
      if (w_capture) begin
        r_vsa  <= cfg_vsa;
        r_vbp  <= cfg_vbp;
        r_vact <= cfg_vact;
        r_vfp  <= cfg_vfp;
        r_hbp  <= cfg_hbp;
        r_hact <= cfg_hact;
        r_hfp  <= cfg_hfp;
      end
    end
  end

  // Next-state: packet states advance only on ack; LINE_END steps or wraps the line.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_next     = r_state;
    w_line_nxt = r_line;
    w_capture  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (enable && (w_cfg_total != '0)) begin
          w_next    = S_SYNC;
          w_capture = 1'b1;
        end
      end
      S_SYNC:  if (pkt_ack) w_next = w_active ? S_HBP : S_BLANK;
      S_HBP:   if (pkt_ack) w_next = S_RGB;
      S_RGB:   if (pkt_ack) w_next = S_HFP;
      S_HFP:   if (pkt_ack) w_next = S_LINE_END;
      S_BLANK: if (pkt_ack) w_next = S_LINE_END;
      S_LINE_END: begin
        if (w_last) begin
          w_line_nxt = '0;
          w_capture  = 1'b1;
          w_next     = (enable && (w_cfg_total != '0)) ? S_SYNC : S_IDLE;
        end else begin
          w_line_nxt = r_line + ONE_LINE;
          w_next     = S_SYNC;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request outputs decoded from the current state and shadow lengths.
  always_comb begin
    pkt_req  = 1'b0;
    pkt_type = PKT_VSS;
    pkt_len  = '0;
    unique case (r_state)
      S_SYNC: begin
        pkt_req  = 1'b1;
        pkt_type = (r_line == '0) ? PKT_VSS : PKT_HSS;
      end
      S_HBP: begin
        pkt_req  = 1'b1;
        pkt_type = PKT_HBP;
        pkt_len  = r_hbp;
      end
      S_RGB: begin
        pkt_req  = 1'b1;
        pkt_type = PKT_RGB;
        pkt_len  = r_hact;
      end
      S_HFP: begin
        pkt_req  = 1'b1;
        pkt_type = PKT_HFP;
        pkt_len  = r_hfp;
      end
      S_BLANK: begin
        pkt_req  = 1'b1;
`ifdef BLANK_LPM_EN
        pkt_type = PKT_LPM;
`else
        pkt_type = PKT_HFP;
        pkt_len  = w_blank_len;
`endif
      end
      default: ;
    endcase
  end

  assign frame_start = (r_state == S_SYNC) && r_entered && (r_line == '0);
  assign line_cnt    = r_line[V_W-1:0];
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_video_packet_scheduler.sv
// Bench for video_packet_scheduler: a frame-level model expands each
// configuration into the expected packet list; one monitor compares every
// accepted packet, hold stability while waiting, and frame_start pulses.
module tb_video_packet_scheduler;
  localparam int V_W = 12;
  localparam int L_W = 16;

  logic           clk_sys = 1'b0;
  logic           rst_n;
  logic           enable;
  logic [V_W-1:0] cfg_vsa, cfg_vbp, cfg_vact, cfg_vfp;
  logic [L_W-1:0] cfg_hbp, cfg_hact, cfg_hfp;
  logic           pkt_req;
  logic [2:0]     pkt_type;
  logic [L_W-1:0] pkt_len;
  logic           pkt_ack;
  logic           frame_start;
  logic [V_W-1:0] line_cnt;
  logic           busy;

  always #5 clk_sys = ~clk_sys;

  video_packet_scheduler #(.V_W(V_W), .L_W(L_W)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .enable(enable),
    .cfg_vsa(cfg_vsa), .cfg_vbp(cfg_vbp), .cfg_vact(cfg_vact), .cfg_vfp(cfg_vfp),
    .cfg_hbp(cfg_hbp), .cfg_hact(cfg_hact), .cfg_hfp(cfg_hfp),
    .pkt_req(pkt_req), .pkt_type(pkt_type), .pkt_len(pkt_len), .pkt_ack(pkt_ack),
    .frame_start(frame_start), .line_cnt(line_cnt), .busy(busy)
  );

  typedef struct {
    int t;
    int len;
    int line;
  } pkt_t;

  pkt_t exp_q[$];
  int   total_checks = 0;
  int   bad_checks   = 0;
  int   fs_count     = 0;
  int   req_cycles   = 0;
  bit   ack_tied     = 1'b1;

  task automatic check(input string name, input longint act, input longint req);
    total_checks++;
    if (act !== req) begin
      bad_checks++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected packet list for one frame, straight from the line-type rules.
  function automatic void push_frame(input int vsa, input int vbp, input int vact,
                                     input int vfp, input int hbp, input int hact,
                                     input int hfp);
    pkt_t p;
    int   tot;
    tot = vsa + vbp + vact + vfp;
    for (int l = 0; l < tot; l++) begin
      p.line = l;
      p.t = (l == 0) ? 0 : 1; p.len = 0; exp_q.push_back(p);
      if (l >= vsa + vbp && l < vsa + vbp + vact) begin
        p.t = 2; p.len = hbp;  exp_q.push_back(p);
        p.t = 3; p.len = hact; exp_q.push_back(p);
        p.t = 4; p.len = hfp;  exp_q.push_back(p);
      end else begin
`ifdef BLANK_LPM_EN
        p.t = 5; p.len = 0;
`else
        p.t = 4; p.len = (hbp + hact + hfp > 65535) ? 65535 : hbp + hact + hfp;
`endif
        exp_q.push_back(p);
      end
    end
  endfunction

  task automatic set_cfg(input int vsa, input int vbp, input int vact, input int vfp,
                         input int hbp, input int hact, input int hfp);
    cfg_vsa = V_W'(vsa); cfg_vbp = V_W'(vbp); cfg_vact = V_W'(vact); cfg_vfp = V_W'(vfp);
    cfg_hbp = L_W'(hbp); cfg_hact = L_W'(hact); cfg_hfp = L_W'(hfp);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk_sys);
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk_sys);
      n++;
    end
    check({name, "_idle_reached"}, longint'(n < 3000), 1);
  endtask

  task automatic wait_fs(input string name, input int target);
    int n = 0;
    while (fs_count < target && n < 3000) begin
      @(negedge clk_sys);
      n++;
    end
    check({name, "_frame_started"}, longint'(n < 3000), 1);
  endtask

  // Ack driver: tied high, or withheld for three cycles of each request.
  initial begin
    int wcnt = 0;
    pkt_ack = 1'b0;
    forever begin
      @(posedge clk_sys);
      #1;
      if (ack_tied) begin
        pkt_ack = 1'b1;
        wcnt = 0;
      end else if (pkt_req) begin
        if (wcnt == 3) begin
          pkt_ack = 1'b1;
          wcnt = 0;
        end else begin
          pkt_ack = 1'b0;
          wcnt++;
        end
      end else begin
        pkt_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Monitor: sampled mid-cycle, ack shown here is the one the next edge sees.
  initial begin
    bit         prev_wait = 1'b0;
    logic [2:0] prev_t = '0;
    logic [L_W-1:0] prev_len = '0;
    pkt_t       e;
    forever begin
      @(negedge clk_sys);
      if (rst_n !== 1'b1) begin
        prev_wait = 1'b0;
      end else begin
        if (prev_wait) begin
          check("hold_req", pkt_req, 1);
          check("hold_type", pkt_type, prev_t);
          check("hold_len", pkt_len, prev_len);
        end
        if (pkt_req) begin
          req_cycles++;
          check("busy_during_req", busy, 1);
        end
        if (frame_start) begin
          fs_count++;
          check("fs_type_vss", pkt_type, 0);
          check("fs_line0", line_cnt, 0);
        end
        if (pkt_req && pkt_ack) begin
          check("pkt_expected", exp_q.size(), (exp_q.size() > 0) ? exp_q.size() : 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pkt_type", pkt_type, e.t);
            check("pkt_len", pkt_len, e.len);
            check("pkt_line", line_cnt, e.line);
          end
        end
        prev_wait = pkt_req && !pkt_ack;
        prev_t    = pkt_type;
        prev_len  = pkt_len;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fs_base;
    int req_base;
    int n;
    rst_n  = 1'b1;
    enable = 1'b0;
    set_cfg(1, 1, 2, 1, 4, 8, 2);
    #2 rst_n = 1'b0;
    #1;
    check("rst_pkt_req", pkt_req, 0);
    check("rst_pkt_type", pkt_type, 0);
    check("rst_pkt_len", pkt_len, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_line_cnt", line_cnt, 0);
    check("rst_busy", busy, 0);
    repeat (3) @(negedge clk_sys);
    #2 rst_n = 1'b1;

    // Pin the model against hand-derived values for the reference frame.
    push_frame(1, 1, 2, 1, 4, 8, 2);
    check("model_size", exp_q.size(), 14);
    check("model_rgb_type", exp_q[6].t, 3);
    check("model_rgb_len", exp_q[6].len, 8);
    check("model_line3_hss", exp_q[8].t, 1);
`ifdef BLANK_LPM_EN
    check("model_blank_type", exp_q[1].t, 5);
    check("model_blank_len", exp_q[1].len, 0);
`else
    check("model_blank_type", exp_q[1].t, 4);
    check("model_blank_len", exp_q[1].len, 14);
`endif
    exp_q.delete();

    // Two back-to-back frames with ack tied high.
    ack_tied = 1'b1;
    push_frame(1, 1, 2, 1, 4, 8, 2);
    push_frame(1, 1, 2, 1, 4, 8, 2);
    fs_base = fs_count;
    enable = 1'b1;
    wait_fs("tied", fs_base + 2);
    enable = 1'b0;
    wait_idle("tied");
    check("tied_queue_empty", exp_q.size(), 0);
    check("tied_frames", fs_count - fs_base, 2);
    check("tied_line_cnt", line_cnt, 0);

    // Delayed ack, enable dropped on line 1, cfg changed mid-frame.
    ack_tied = 1'b0;
    push_frame(1, 1, 2, 1, 4, 8, 2);
    fs_base = fs_count;
    enable = 1'b1;
    n = 0;
    while (!(busy === 1'b1 && line_cnt == 1) && n < 3000) begin
      @(negedge clk_sys);
      n++;
    end
    check("slow_line1_reached", longint'(n < 3000), 1);
    enable = 1'b0;
    cfg_hact = L_W'(5);
    wait_idle("slow");
    check("slow_queue_empty", exp_q.size(), 0);
    check("slow_frames", fs_count - fs_base, 1);
    check("slow_line_cnt", line_cnt, 0);
    check("slow_busy", busy, 0);
    cfg_hact = L_W'(8);

    // Reset while an RGB request is pending.
    push_frame(1, 1, 2, 1, 4, 8, 2);
    enable = 1'b1;
    n = 0;
    while (!(pkt_req === 1'b1 && pkt_type == 3'd3) && n < 3000) begin
      @(negedge clk_sys);
      n++;
    end
    check("rgb_reached", longint'(n < 3000), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_pkt_req", pkt_req, 0);
    check("midrst_busy", busy, 0);
    check("midrst_line_cnt", line_cnt, 0);
    check("midrst_pkt_len", pkt_len, 0);
    exp_q.delete();
    enable = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    #2 rst_n = 1'b1;
    ack_tied = 1'b1;
    push_frame(1, 1, 2, 1, 4, 8, 2);
    fs_base = fs_count;
    enable = 1'b1;
    wait_fs("after_rst", fs_base + 1);
    enable = 1'b0;
    wait_idle("after_rst");
    check("after_rst_queue_empty", exp_q.size(), 0);

    // All vertical counts zero: must never leave IDLE.
    set_cfg(0, 0, 0, 0, 4, 8, 2);
    req_base = req_cycles;
    enable = 1'b1;
    repeat (40) @(negedge clk_sys);
    check("zero_busy", busy, 0);
    check("zero_req_cycles", req_cycles - req_base, 0);
    enable = 1'b0;

    // Zero-length HBP/HFP on an active line, then one blanking line.
    set_cfg(0, 0, 1, 1, 0, 3, 0);
    push_frame(0, 0, 1, 1, 0, 3, 0);
    check("model_zero_hbp_type", exp_q[1].t, 2);
    check("model_zero_hbp_len", exp_q[1].len, 0);
    enable = 1'b1;
    fs_base = fs_count;
    wait_fs("zlen", fs_base + 1);
    enable = 1'b0;
    wait_idle("zlen");
    check("zlen_queue_empty", exp_q.size(), 0);

    // Blanking length overflow.
    set_cfg(1, 0, 0, 0, 'h8000, 'h8000, 'h8000);
    push_frame(1, 0, 0, 0, 'h8000, 'h8000, 'h8000);
`ifdef BLANK_LPM_EN
    check("model_sat_type", exp_q[1].t, 5);
    check("model_sat_len", exp_q[1].len, 0);
`else
    check("model_sat_type", exp_q[1].t, 4);
    check("model_sat_len", exp_q[1].len, 'hFFFF);
`endif
    enable = 1'b1;
    fs_base = fs_count;
    wait_fs("sat", fs_base + 1);
    enable = 1'b0;
    wait_idle("sat");
    check("sat_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule

// File: doc/video_packet_scheduler.md
VIDEO_PACKET_SCHEDULER -- requirements
Module: video_packet_scheduler

Interface
REQ-001 Parameter V_W, default 12, width of the vertical line-count fields.
REQ-002 Parameter L_W, default 16, width of the packet payload-length fields.
REQ-003 clk_sys  input  1  system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 enable  input  1  run request; sampled only in IDLE and at frame end.
REQ-006 cfg_vsa, cfg_vbp, cfg_vact, cfg_vfp  input  V_W each  vertical sync, back-porch, active and front-porch line counts.
REQ-007 cfg_hbp, cfg_hact, cfg_hfp  input  L_W each  HBP, RGB and HFP payload lengths in bytes.
REQ-008 pkt_req  output  1  packet request to the assembler.
REQ-009 pkt_type  output  3  packet code: 0 VSS, 1 HSS, 2 HBP, 3 RGB, 4 HFP, 5 LPM.
REQ-010 pkt_len  output  L_W  payload length for the current request.
REQ-011 pkt_ack  input  1  assembler accepts the current request.
REQ-012 frame_start  output  1  one-cycle pulse when the VSS request of a frame is first asserted.
REQ-013 line_cnt  output  V_W  index of the current line within the frame, 0-based.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The FSM shall use the states IDLE, SYNC, HBP, RGB, HFP, BLANK and LINE_END.
REQ-016 IDLE -> SYNC when enable=1 and the line total (vsa+vbp+vact+vfp, computed V_W+2 bits wide) is nonzero; otherwise the FSM shall remain in IDLE.
REQ-017 On leaving IDLE and at every frame wrap, all cfg_* inputs shall be captured into shadow registers; changes mid-frame shall have no effect.
REQ-018 SYNC shall request VSS on line 0 and HSS on every other line, with pkt_len=0.
REQ-019 Lines in [vsa+vbp, vsa+vbp+vact) are active: SYNC -> HBP -> RGB -> HFP -> LINE_END, each with its shadow length.
REQ-020 All other lines are blanking: SYNC -> BLANK -> LINE_END.
REQ-021 A request (pkt_req, pkt_type, pkt_len) shall be held stable until the cycle in which pkt_ack=1; the state shall advance on that edge.
REQ-022 The next request shall be presented in the cycle after the ack; pkt_req may remain high across back-to-back packets.
REQ-023 pkt_ack while pkt_req=0 shall be ignored.
REQ-024 Zero-length HBP or HFP shall still be requested with pkt_len=0; a zero-count vertical region shall contribute no lines.
REQ-025 LINE_END (pkt_req=0, one cycle) shall increment line_cnt; at line total-1 it shall wrap line_cnt to 0.
REQ-026 At wrap, SYNC shall follow if enable=1; otherwise IDLE shall follow. Deasserting enable mid-frame shall never truncate a frame.
REQ-027 frame_start shall pulse in the first cycle of SYNC on line 0 only.

Reset
REQ-028 On rst_n=0 the FSM shall enter IDLE asynchronously, with pkt_req=0, pkt_type=0, pkt_len=0, frame_start=0, line_cnt=0, busy=0 and the shadow registers cleared.
REQ-029 Reset asserted mid-packet shall drop the request immediately; there shall be no resume.

Configuration
REQ-030 Macro BLANK_LPM_EN: when defined, BLANK shall request LPM with pkt_len=0.
REQ-031 When BLANK_LPM_EN is undefined, BLANK shall request HFP with pkt_len=hbp+hact+hfp, saturated to all-ones on overflow.

Verification
REQ-032 vsa=1, vbp=1, vact=2, vfp=1, hbp=4, hact=8, hfp=2, ack tied 1 -> per frame: VSS,BLANK; HSS,BLANK; HSS,HBP(4),RGB(8),HFP(2) twice; HSS,BLANK. frame_start pulses once per 5 lines.
REQ-033 Same config, ack delayed 3 cycles per packet -> type/len stable throughout each wait; no packet skipped or duplicated.
REQ-034 enable dropped on line 1 -> frame completes through line 4, then IDLE with busy=0, line_cnt=0.
REQ-035 rst_n pulsed low during RGB -> pkt_req=0 immediately, IDLE; next frame starts at VSS, line 0.
REQ-036 All vertical counts 0 with enable=1 -> stays IDLE, pkt_req never asserted.
REQ-037 hbp=hact=hfp=0x8000, BLANK_LPM_EN undefined -> blanking HFP pkt_len=0xFFFF; with BLANK_LPM_EN defined -> type 5, len 0.
